// File: rtl/exp_accel_avs.sv
// Avalon-MM exponent accelerator: RESULT = BASE**EXP mod 2**W by right-to-left
// square-and-multiply, one exponent bit per clock, with an exact overflow flag.
module exp_accel_avs #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [2:0]   avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [W-1:0] avs_writedata,
    output logic [W-1:0] avs_readdata,
    output logic         irq
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t state, state_nxt;

    logic         irq_en, done, ovf_flag;
    logic [W-1:0] base_reg, exp_reg, result, cycles;
    logic [W-1:0] r, b, e;
    logic         b_ovf, acc_ovf;

    logic           busy, wr_ctrl, start_req, clr_done_wr, last_bit;
    logic [2*W-1:0] p_r, p_b;
    logic [W-1:0]   r_new;
    logic           ovf_new;

    assign busy        = (state != IDLE);
    assign wr_ctrl     = avs_write && (avs_address == 3'd0);
    assign start_req   = wr_ctrl && avs_writedata[0] && (state == IDLE);
    assign clr_done_wr = wr_ctrl && avs_writedata[2];
    assign last_bit    = (e[W-1:1] == '0);
    assign irq         = done & irq_en;

    assign p_r = (2*W)'(r) * (2*W)'(b);
    assign p_b = (2*W)'(b) * (2*W)'(b);

    // A squared base that already overflowed makes any product using it overflow,
    // since base >= 2 whenever the square exceeds W bits; that keeps OVF exact.
    assign r_new   = e[0] ? p_r[W-1:0] : r;
    assign ovf_new = acc_ovf | (e[0] & (b_ovf | (|p_r[2*W-1:W])));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_req) state_nxt = LOAD;
            LOAD: state_nxt = (exp_reg == '0) ? IDLE : RUN;
            RUN:  if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            done     <= 1'b0;
            ovf_flag <= 1'b0;
            base_reg <= '0;
            exp_reg  <= '0;
            result   <= '0;
            cycles   <= '0;
            r        <= '0;
            b        <= '0;
            e        <= '0;
            b_ovf    <= 1'b0;
            acc_ovf  <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= avs_writedata[1];
            if (avs_write && avs_address == 3'd2) base_reg <= avs_writedata;
            if (avs_write && avs_address == 3'd3) exp_reg  <= avs_writedata;
            if (clr_done_wr) done <= 1'b0;
            if (start_req) begin
                done     <= 1'b0;
                ovf_flag <= 1'b0;
                cycles   <= '0;
            end

            // Completion is written after the CLR_DONE handling so a same-cycle set wins.
            case (state)
                LOAD: begin
                    r       <= W'(1);
                    b       <= base_reg;
                    e       <= exp_reg;
                    b_ovf   <= 1'b0;
                    acc_ovf <= 1'b0;
                    cycles  <= W'(1);
                    if (exp_reg == '0) begin
                        result <= W'(1);
                        done   <= 1'b1;
                    end
                end
                RUN: begin
                    r       <= r_new;
                    acc_ovf <= ovf_new;
                    b       <= p_b[W-1:0];
                    b_ovf   <= b_ovf | (|p_b[2*W-1:W]);
                    e       <= e >> 1;
                    cycles  <= cycles + W'(1);
                    if (last_bit) begin
                        result   <= r_new;
                        ovf_flag <= ovf_new;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered read port: sampled on the read strobe, held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                3'd0:    avs_readdata <= {{(W-2){1'b0}}, irq_en, 1'b0};
                3'd1:    avs_readdata <= {{(W-3){1'b0}}, ovf_flag, done, busy};
                3'd2:    avs_readdata <= base_reg;
                3'd3:    avs_readdata <= exp_reg;
                3'd4:    avs_readdata <= result;
                3'd5:    avs_readdata <= cycles;
                default: avs_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_accel_avs.sv
// Directed bench for exp_accel_avs: register map, op latency, overflow, irq and async reset.
module tb_exp_accel_avs;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   avs_address = '0;
    logic         avs_read = 1'b0;
    logic         avs_write = 1'b0;
    logic [W-1:0] avs_writedata = '0;
    logic [W-1:0] avs_readdata;
    logic         irq;

    int total = 0;
    int bad   = 0;

    exp_accel_avs #(.W(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    // Polls STATUS every cycle; counts samples with BUSY set until it clears.
    task automatic wait_idle(output int busy_cnt);
        logic seen_idle;
        seen_idle = 1'b0;
        busy_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            avs_address = 3'd1;
            avs_read    = 1'b1;
            tick();
            if (avs_readdata[0]) busy_cnt++;
            else begin
                seen_idle = 1'b1;
                break;
            end
        end
        avs_read = 1'b0;
        check("idle_within_bound", {31'd0, seen_idle}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] bs, input logic [W-1:0] ex,
                          input logic [W-1:0] ctrl, output int busy_cnt);
        wr(3'd2, bs);
        wr(3'd3, ex);
        wr(3'd0, ctrl);
        wait_idle(busy_cnt);
    endtask

    initial begin
        logic [W-1:0] d;
        int           nb;

        repeat (3) tick();
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        rd(3'd1, d); check("reset_status", d, 32'd0);
        rd(3'd4, d); check("reset_result", d, 32'd0);

        // 3**5
        run_op(32'd3, 32'd5, 32'd1, nb);
        check("t1_busy_cycles", 32'(nb), 32'd4);
        rd(3'd4, d); check("t1_result", d, 32'd243);
        rd(3'd1, d); check("t1_status", d, 32'd2);
        rd(3'd5, d); check("t1_cycles", d, 32'd4);

        // 2**31 fits, 2**32 overflows
        run_op(32'd2, 32'd31, 32'd1, nb);
        rd(3'd4, d); check("t2a_result", d, 32'h8000_0000);
        rd(3'd1, d); check("t2a_status", d, 32'd2);
        run_op(32'd2, 32'd32, 32'd1, nb);
        rd(3'd4, d); check("t2b_result", d, 32'd0);
        rd(3'd1, d); check("t2b_status", d, 32'd6);
        rd(3'd5, d); check("t2b_cycles", d, 32'd7);

        // zero exponent and zero base
        run_op(32'd0, 32'd0, 32'd1, nb);
        check("t3a_busy", 32'(nb), 32'd1);
        rd(3'd4, d); check("t3a_result", d, 32'd1);
        rd(3'd1, d); check("t3a_status", d, 32'd2);
        run_op(32'd7, 32'd0, 32'd1, nb);
        check("t3b_busy", 32'(nb), 32'd1);
        rd(3'd4, d); check("t3b_result", d, 32'd1);
        rd(3'd5, d); check("t3b_cycles", d, 32'd1);
        run_op(32'd0, 32'd9, 32'd1, nb);
        rd(3'd4, d); check("t3c_result", d, 32'd0);
        rd(3'd1, d); check("t3c_status", d, 32'd2);

        // 3**(2**32-1) = 3**-1 mod 2**32 since 3**(2**32) == 1; operand writes mid-op ignored
        wr(3'd2, 32'd3);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd0, 32'd1);
        repeat (5) tick();
        wr(3'd2, 32'd5);
        wr(3'd0, 32'd1);
        rd(3'd1, d); check("t4_busy_mid", d, 32'd1);
        rd(3'd4, d); check("t4_result_held", d, 32'd0);
        wait_idle(nb);
        rd(3'd4, d); check("t4_result", d, 32'hAAAA_AAAB);
        rd(3'd1, d); check("t4_status", d, 32'd6);
        rd(3'd5, d); check("t4_cycles", d, 32'd33);
        rd(3'd2, d); check("t4_base", d, 32'd5);

        // irq timing: 10**3 spends LOAD + 2 RUN cycles
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd3);
        check("t5_irq_load", {31'd0, irq}, 32'd0);
        tick(); check("t5_irq_run1", {31'd0, irq}, 32'd0);
        tick(); check("t5_irq_run2", {31'd0, irq}, 32'd0);
        tick(); check("t5_irq_done", {31'd0, irq}, 32'd1);
        rd(3'd4, d); check("t5_result", d, 32'd1000);
        wr(3'd0, 32'd6);
        check("t5_irq_clr", {31'd0, irq}, 32'd0);
        rd(3'd1, d); check("t5_status_clr", d, 32'd0);
        run_op(32'd10, 32'd3, 32'd1, nb);
        check("t5_irq_disabled", {31'd0, irq}, 32'd0);
        rd(3'd1, d); check("t5_done_no_irq", d, 32'd2);

        // async reset mid-run
        wr(3'd0, 32'd2);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd0, 32'd3);
        repeat (3) tick();
        rd(3'd3, d); check("t6_pre_rdata", d, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        #1;
        check("t6_rst_rdata", avs_readdata, 32'd0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        rd(3'd1, d); check("t6_status_after", d, 32'd0);
        rd(3'd2, d); check("t6_base_after", d, 32'd0);
        run_op(32'd7, 32'd2, 32'd1, nb);
        check("t6_busy", 32'(nb), 32'd3);
        rd(3'd4, d); check("t6_result", d, 32'd49);

        // register map readback and latency
        wr(3'd0, 32'd2);
        wr(3'd6, 32'h1234_5678);
        wr(3'd7, 32'hDEAD_BEEF);
        rd(3'd0, d); check("map_ctrl", d, 32'd2);
        rd(3'd1, d); check("map_status", d, 32'd2);
        rd(3'd2, d); check("map_base", d, 32'd7);
        rd(3'd3, d); check("map_exp", d, 32'd2);
        rd(3'd4, d); check("map_result", d, 32'd49);
        rd(3'd5, d); check("map_cycles", d, 32'd3);
        rd(3'd6, d); check("map_addr6", d, 32'd0);
        rd(3'd7, d); check("map_addr7", d, 32'd0);
        avs_address = 3'd4;
        avs_read    = 1'b1;
        #2;
        check("lat_not_early", avs_readdata, 32'd0);
        tick();
        avs_read    = 1'b0;
        check("lat_one_cycle", avs_readdata, 32'd49);
        avs_address = 3'd2;
        tick();
        check("rdata_hold", avs_readdata, 32'd49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
